// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALU operation classes, ALU control codes, FSM states and mux selects.
package multicycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [2:0] ALUCTRL_AND = 3'b000;
  localparam logic [2:0] ALUCTRL_OR  = 3'b001;
  localparam logic [2:0] ALUCTRL_ADD = 3'b010;
  localparam logic [2:0] ALUCTRL_SUB = 3'b110;
  localparam logic [2:0] ALUCTRL_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_RTWB    = 4'd7,
    S_IMMEXEC = 4'd8,
    S_IMMWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode: maps the FSM's ALU operation class (and funct for
// R-type) onto the ALU control code, zero-padded to ALUCTRL_W bits.
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [1:0]           aluop,
  input  logic [5:0]           funct,
  output logic [ALUCTRL_W-1:0] aluctrl
);

  logic [2:0] ctrl3;

  // Select the 3-bit ALU code; unknown functs fall back to AND (000).
  always_comb begin
    ctrl3 = ALUCTRL_AND;
    case (aluop)
      ALUOP_ADD: ctrl3 = ALUCTRL_ADD;
      ALUOP_SUB: ctrl3 = ALUCTRL_SUB;
      ALUOP_OR:  ctrl3 = ALUCTRL_OR;
      default: begin
        case (funct)
          FN_ADD:  ctrl3 = ALUCTRL_ADD;
          FN_SUB:  ctrl3 = ALUCTRL_SUB;
          FN_AND:  ctrl3 = ALUCTRL_AND;
          FN_OR:   ctrl3 = ALUCTRL_OR;
          FN_SLT:  ctrl3 = ALUCTRL_SLT;
          default: ctrl3 = ALUCTRL_AND;
        endcase
      end
    endcase
    aluctrl = '0;
    aluctrl[2:0] = ctrl3;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit. A Moore-style FSM sequences each instruction
// over several cycles; outputs are decoded from the registered state, with
// the memory handshake (mem_ready) and branch flag (zero) qualifying the
// strobes of the state they belong to. rst forces every output low.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int ALUCTRL_W  = 3,
  parameter bit ENABLE_BNE = 1'b1,
  parameter bit ENABLE_ORI = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcen,
  output logic                 iord,
  output logic                 mem_req,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 memtoreg,
  output logic                 regdst,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 extop,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] aluctrl,
  output logic                 illegal_op,
  output logic [3:0]           state_dbg
);

  state_e state_q, state_d;
  logic [1:0] aluop;
  logic alu_en;
  logic [ALUCTRL_W-1:0] aluctrl_dec;
  logic is_lw, is_sw, is_rtype, is_imm, is_ori, is_br, is_bne, is_j;

  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_rtype = (op == OP_RTYPE);
  assign is_ori   = ENABLE_ORI && (op == OP_ORI);
  assign is_bne   = ENABLE_BNE && (op == OP_BNE);
  assign is_imm   = (op == OP_ADDI) || is_ori;
  assign is_br    = (op == OP_BEQ) || is_bne;
  assign is_j     = (op == OP_J);

  multicycle_controller_alu_decoder #(
    .ALUCTRL_W(ALUCTRL_W)
  ) u_alu_dec (
    .aluop  (aluop),
    .funct  (funct),
    .aluctrl(aluctrl_dec)
  );

  // States without an ALU operation drive aluctrl low.
  assign aluctrl = alu_en ? aluctrl_dec : '0;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and per-state control decode, all forced low during reset.
  always_comb begin
    state_d    = state_q;
    pcen       = 1'b0;
    iord       = 1'b0;
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RT;
    extop      = 1'b1;
    pcsrc      = PCSRC_ALU;
    aluop      = ALUOP_ADD;
    alu_en     = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        alu_en  = 1'b1;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = SRCB_IMM_SH2;
        alu_en  = 1'b1;
        if (is_lw || is_sw) state_d = S_MEMADR;
        else if (is_rtype)  state_d = S_RTEXEC;
        else if (is_imm)    state_d = S_IMMEXEC;
        else if (is_br)     state_d = S_BRANCH;
        else if (is_j)      state_d = S_JUMP;
        else begin
          state_d    = S_FETCH;
          illegal_op = 1'b1;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        alu_en  = 1'b1;
        state_d = is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTEXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        alu_en  = 1'b1;
        state_d = S_RTWB;
      end
      S_RTWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_IMMEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        alu_en  = 1'b1;
        if (is_ori) begin
          aluop = ALUOP_OR;
          extop = 1'b0;
        end
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        alu_en  = 1'b1;
        pcsrc   = PCSRC_ALUOUT;
        pcen    = is_bne ? ~zero : zero;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    state_dbg = state_q;
    if (rst) begin
      pcen       = 1'b0;
      iord       = 1'b0;
      mem_req    = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      extop      = 1'b0;
      pcsrc      = 2'b00;
      alu_en     = 1'b0;
      illegal_op = 1'b0;
      state_dbg  = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances (all options enabled with a
// 3-bit ALU code; bne/ori disabled with a 4-bit ALU code) driven by random
// instruction streams and compared cycle by cycle with a per-instruction
// reference model.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  typedef struct packed {
    logic       pcen, iord, mem_req, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [1:0] pcsrc;
    logic [3:0] aluctrl;
    logic       illegal_op;
    logic [3:0] state;
  } ctl_t;

  localparam int CL_R = 0, CL_LW = 1, CL_SW = 2, CL_IMM = 3, CL_BR = 4, CL_J = 5, CL_ILL = 6;

  logic clk = 1'b0;
  logic rst, zero, mem_ready;
  logic [5:0] op, funct;

  logic pcen_a, iord_a, mem_req_a, memwrite_a, irwrite_a, memtoreg_a, regdst_a, regwrite_a, alusrca_a, extop_a, illegal_op_a;
  logic [1:0] alusrcb_a, pcsrc_a;
  logic [2:0] aluctrl_a;
  logic [3:0] state_dbg_a;
  logic pcen_b, iord_b, mem_req_b, memwrite_b, irwrite_b, memtoreg_b, regdst_b, regwrite_b, alusrca_b, extop_b, illegal_op_b;
  logic [1:0] alusrcb_b, pcsrc_b;
  logic [3:0] aluctrl_b;
  logic [3:0] state_dbg_b;

  ctl_t obs_a, obs_b;
  ctl_t exp_q[$];
  ctl_t obs_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_controller dut_a (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen_a), .iord(iord_a), .mem_req(mem_req_a), .memwrite(memwrite_a), .irwrite(irwrite_a),
    .memtoreg(memtoreg_a), .regdst(regdst_a), .regwrite(regwrite_a), .alusrca(alusrca_a),
    .alusrcb(alusrcb_a), .extop(extop_a), .pcsrc(pcsrc_a), .aluctrl(aluctrl_a),
    .illegal_op(illegal_op_a), .state_dbg(state_dbg_a)
  );

  multicycle_controller #(.ALUCTRL_W(4), .ENABLE_BNE(1'b0), .ENABLE_ORI(1'b0)) dut_b (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen_b), .iord(iord_b), .mem_req(mem_req_b), .memwrite(memwrite_b), .irwrite(irwrite_b),
    .memtoreg(memtoreg_b), .regdst(regdst_b), .regwrite(regwrite_b), .alusrca(alusrca_b),
    .alusrcb(alusrcb_b), .extop(extop_b), .pcsrc(pcsrc_b), .aluctrl(aluctrl_b),
    .illegal_op(illegal_op_b), .state_dbg(state_dbg_b)
  );

  assign obs_a = {pcen_a, iord_a, mem_req_a, memwrite_a, irwrite_a, memtoreg_a, regdst_a, regwrite_a,
                  alusrca_a, alusrcb_a, extop_a, pcsrc_a, 1'b0, aluctrl_a, illegal_op_a, state_dbg_a};
  assign obs_b = {pcen_b, iord_b, mem_req_b, memwrite_b, irwrite_b, memtoreg_b, regdst_b, regwrite_b,
                  alusrca_b, alusrcb_b, extop_b, pcsrc_b, aluctrl_b, illegal_op_b, state_dbg_b};

  // ---------------- reference model ----------------
  function automatic int cls(input logic [5:0] o, input bit sel);
    case (o)
      6'b000000: return CL_R;
      6'b100011: return CL_LW;
      6'b101011: return CL_SW;
      6'b001000: return CL_IMM;
      6'b001101: return sel ? CL_ILL : CL_IMM;
      6'b000100: return CL_BR;
      6'b000101: return sel ? CL_ILL : CL_BR;
      6'b000010: return CL_J;
      default:   return CL_ILL;
    endcase
  endfunction

  function automatic logic [3:0] funct_code(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic ctl_t model(input state_e s, input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input logic mr, input bit sel);
    ctl_t c;
    c = '0;
    c.state = s;
    c.extop = 1'b1;
    case (s)
      S_FETCH:   begin c.mem_req = 1; c.alusrcb = 2'b01; c.aluctrl = 4'b0010; c.irwrite = mr; c.pcen = mr; end
      S_DECODE:  begin c.alusrcb = 2'b11; c.aluctrl = 4'b0010; c.illegal_op = (cls(o, sel) == CL_ILL); end
      S_MEMADR:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluctrl = 4'b0010; end
      S_MEMRD:   begin c.mem_req = 1; c.iord = 1; end
      S_MEMWB:   begin c.regwrite = 1; c.memtoreg = 1; end
      S_MEMWR:   begin c.mem_req = 1; c.iord = 1; c.memwrite = 1; end
      S_RTEXEC:  begin c.alusrca = 1; c.aluctrl = funct_code(f); end
      S_RTWB:    begin c.regwrite = 1; c.regdst = 1; end
      S_IMMEXEC: begin
        c.alusrca = 1; c.alusrcb = 2'b10;
        if (o == 6'b001101) begin c.aluctrl = 4'b0001; c.extop = 0; end
        else c.aluctrl = 4'b0010;
      end
      S_IMMWB:   c.regwrite = 1;
      S_BRANCH:  begin c.alusrca = 1; c.aluctrl = 4'b0110; c.pcsrc = 2'b01; c.pcen = (o == 6'b000101) ? ~z : z; end
      S_JUMP:    begin c.pcsrc = 2'b10; c.pcen = 1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // ---------------- stimulus plumbing (no checking) ----------------
  task automatic cycle(input bit sel, input logic r, input logic mr, input logic z, output ctl_t got);
    rst = r; mem_ready = mr; zero = z;
    @(negedge clk);
    got = sel ? obs_b : obs_a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit sel, input int n);
    ctl_t got;
    for (int i = 0; i < n; i++) begin
      op = 6'($urandom); funct = 6'($urandom);
      cycle(sel, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, got);
      exp_q.push_back('0);
      obs_q.push_back(got);
    end
  endtask

  task automatic run_instr(input bit sel, input logic [5:0] o, input logic [5:0] f,
                           input logic zb, input int fw, input int mw);
    state_e path[$];
    ctl_t got;
    logic mr, z;
    int waits;
    bit is_mem;
    op = o; funct = f;
    path = {S_FETCH, S_DECODE};
    case (cls(o, sel))
      CL_R:    path = {path, S_RTEXEC, S_RTWB};
      CL_LW:   path = {path, S_MEMADR, S_MEMRD, S_MEMWB};
      CL_SW:   path = {path, S_MEMADR, S_MEMWR};
      CL_IMM:  path = {path, S_IMMEXEC, S_IMMWB};
      CL_BR:   path.push_back(S_BRANCH);
      CL_J:    path.push_back(S_JUMP);
      default: ;
    endcase
    foreach (path[i]) begin
      is_mem = (path[i] == S_FETCH) || (path[i] == S_MEMRD) || (path[i] == S_MEMWR);
      waits = !is_mem ? 0 : (path[i] == S_FETCH) ? fw : mw;
      for (int w = 0; w <= waits; w++) begin
        mr = is_mem ? (w == waits) : ($urandom_range(0, 1) == 1);
        z  = (path[i] == S_BRANCH) ? zb : ($urandom_range(0, 1) == 1);
        cycle(sel, 1'b0, mr, z, got);
        exp_q.push_back(model(path[i], o, f, z, mr, sel));
        obs_q.push_back(got);
      end
    end
    z = $urandom_range(0, 1) == 1;
    cycle(sel, 1'b0, 1'b0, z, got);
    exp_q.push_back(model(S_FETCH, o, f, z, 1'b0, sel));
    obs_q.push_back(got);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    exp_q.delete(); obs_q.delete();
    do_reset(1'b0, 3);
    run_instr(1'b0, 6'b000010, 6'($urandom), 1'b0, 0, 0);
    foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL reset cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_lw();
    int nreg;
    exp_q.delete(); obs_q.delete();
    do_reset(1'b0, 1);
    run_instr(1'b0, 6'b100011, 6'($urandom), 1'b0, 0, 0);
    nreg = 0;
    foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL lw cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].regwrite === 1'b1) nreg++;
    end
    n_vec++;
    if (nreg !== 1) begin
      n_err++;
      $display("FAIL lw_regwrite_count got %0d exp 1", nreg);
    end
    n_vec++;
    if (obs_q[5].regwrite !== 1'b1 || obs_q[5].memtoreg !== 1'b1 || obs_q[6].state !== 4'(S_FETCH)) begin
      n_err++;
      $display("FAIL lw_cycle5 got rw=%b m2r=%b next=%0d exp rw=1 m2r=1 next=%0d",
               obs_q[5].regwrite, obs_q[5].memtoreg, obs_q[6].state, S_FETCH);
    end
  endtask

  task automatic test_sw_wait();
    int nmw;
    exp_q.delete(); obs_q.delete();
    do_reset(1'b0, 1);
    run_instr(1'b0, 6'b101011, 6'($urandom), 1'b0, 1, 3);
    nmw = 0;
    foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL sw cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].memwrite === 1'b1) nmw++;
    end
    n_vec++;
    if (nmw !== 4) begin
      n_err++;
      $display("FAIL sw_memwrite_cycles got %0d exp 4", nmw);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fl[7];
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000011, 6'b111111};
    exp_q.delete(); obs_q.delete();
    do_reset(1'b0, 1);
    foreach (fl[k]) run_instr(1'b0, 6'b000000, fl[k], 1'b0, $urandom_range(0, 2), 0);
    foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rtype cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_branch();
    exp_q.delete(); obs_q.delete();
    do_reset(1'b0, 1);
    run_instr(1'b0, 6'b000100, 6'($urandom), 1'b1, 0, 0);
    run_instr(1'b0, 6'b000100, 6'($urandom), 1'b0, 0, 0);
    run_instr(1'b0, 6'b000101, 6'($urandom), 1'b0, 0, 0);
    run_instr(1'b0, 6'b000101, 6'($urandom), 1'b1, 1, 0);
    foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL branch cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_imm_enabled();
    exp_q.delete(); obs_q.delete();
    do_reset(1'b0, 1);
    run_instr(1'b0, 6'b001101, 6'($urandom), 1'b0, 0, 0);
    run_instr(1'b0, 6'b001000, 6'($urandom), 1'b0, 2, 0);
    foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL imm cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_options_disabled();
    logic [5:0] ol[6];
    ol = '{6'b001101, 6'b000101, 6'b001000, 6'b000000, 6'b100011, 6'b111100};
    exp_q.delete(); obs_q.delete();
    do_reset(1'b1, 1);
    foreach (ol[k]) run_instr(1'b1, ol[k], 6'b101010, $urandom_range(0, 1) == 1, 0, $urandom_range(0, 2));
    foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL disabled cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    ctl_t got;
    exp_q.delete(); obs_q.delete();
    do_reset(1'b0, 1);
    op = 6'b100011; funct = 6'($urandom);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, got); exp_q.push_back(model(S_FETCH,  op, funct, 1'b0, 1'b1, 1'b0)); obs_q.push_back(got);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, got); exp_q.push_back(model(S_DECODE, op, funct, 1'b0, 1'b0, 1'b0)); obs_q.push_back(got);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, got); exp_q.push_back(model(S_MEMADR, op, funct, 1'b0, 1'b0, 1'b0)); obs_q.push_back(got);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, got); exp_q.push_back(model(S_MEMRD,  op, funct, 1'b0, 1'b0, 1'b0)); obs_q.push_back(got);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, got); exp_q.push_back(model(S_MEMRD,  op, funct, 1'b0, 1'b0, 1'b0)); obs_q.push_back(got);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, got); exp_q.push_back('0); obs_q.push_back(got);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, got); exp_q.push_back(model(S_FETCH,  op, funct, 1'b0, 1'b0, 1'b0)); obs_q.push_back(got);
    foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL reset_mid cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ol[10];
    logic [5:0] fl[6];
    ol = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b001101, 6'b000010, 6'b111111, 6'b010001};
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b010101};
    exp_q.delete(); obs_q.delete();
    do_reset(1'b0, 1);
    for (int k = 0; k < 40; k++)
      run_instr(1'b0, ol[$urandom_range(0, 9)], fl[$urandom_range(0, 5)], $urandom_range(0, 1) == 1,
                $urandom_range(0, 3), $urandom_range(0, 3));
    foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL b2b cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b0; op = '0; funct = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_branch();
    test_imm_enabled();
    test_options_disabled();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Next-generation MIPS control unit for the multicycle datapath: a Moore FSM sequences each instruction over 3-5 cycles instead of decoding it in a single cycle. It supports R-type (add/sub/and/or/slt), lw, sw, beq, addi and j, plus optional bne and ori. It adds a memory wait-state handshake and illegal-opcode reporting. It sits between the instruction register (op/funct) and the shared-memory multicycle datapath.

Parameters:
ALUCTRL_W, 3, width of ALU control output
ENABLE_BNE, 1, 1 = decode bne (op 000101), 0 = treat it as illegal
ENABLE_ORI, 1, 1 = decode ori (op 001101), 0 = treat it as illegal

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
op  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the access this cycle
pcen  output  1  PC register enable
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_req  output  1  memory access request
memwrite  output  1  memory write strobe
irwrite  output  1  IR load enable
memtoreg  output  1  register write data: 0 = ALUOut, 1 = MDR
regdst  output  1  write register: 0 = rt, 1 = rd
regwrite  output  1  register file write enable
alusrca  output  1  ALU A: 0 = PC, 1 = rs
alusrcb  output  2  ALU B: 00 = rt, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
extop  output  1  immediate extension: 1 = sign, 0 = zero (ori)
pcsrc  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
aluctrl  output  ALUCTRL_W  ALU operation
illegal_op  output  1  one-cycle pulse on an undecodable opcode
state_dbg  output  4  current state encoding

Interface fixed: one clock, clk; rst is synchronous and active-high.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, IMMEXEC, IMMWB, BRANCH, JUMP.
- Reset: while rst=1, every output is forced to 0 and aluctrl=0. The state becomes FETCH on the next edge.
- Default for every control output is 0 unless listed for a state. Register-write and memory-write strobes are never X.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop add, pcsrc=00.
  - irwrite and pcen assert only when mem_ready=1; the FSM advances to DECODE only then.
  - Otherwise it stays in FETCH with PC and IR unchanged.
- DECODE: alusrca=0, alusrcb=11, aluop add (branch-target precompute). Next state by op:
  - lw/sw -> MEMADR
  - R-type (000000) -> RTEXEC
  - addi, or enabled ori -> IMMEXEC
  - beq, or enabled bne -> BRANCH
  - j -> JUMP
  - anything else -> FETCH, with illegal_op=1 for that cycle.
- MEMADR: alusrca=1, alusrcb=10, add. Next state MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. Next state FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Hold until mem_ready, then go to FETCH. memwrite stays high for the whole hold.
- RTEXEC: alusrca=1, alusrcb=00, aluop funct. Next state RTWB.
- RTWB: regwrite=1, regdst=1, memtoreg=0. Next state FETCH.
- IMMEXEC: alusrca=1, alusrcb=10.
  - addi: add, extop=1.
  - ori: or, extop=0.
  - Next state IMMWB.
- IMMWB: regwrite=1, regdst=0, memtoreg=0. Next state FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01.
  - pcen = zero for beq, ~zero for bne.
  - Next state FETCH.
- JUMP: pcsrc=10, pcen=1. Next state FETCH.
- extop=1 in every state except IMMEXEC with ori.
- aluop-to-aluctrl mapping:
  - add = 010, sub = 110, or = 001.
  - funct mode: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other -> 000.
  - Upper bits are zero-padded when ALUCTRL_W > 3.
- An unknown funct does not raise illegal_op; the instruction still writes back.
- rst asserted in any state, including during a mem_ready hold, aborts the instruction: no write strobe fires on the reset cycle.

Decomposition:
- Shared package: opcode and funct constants, aluop encodings (ADD, SUB, FUNCT, OR), aluctrl encodings, state encoding (4 bits), alusrcb and pcsrc select codes.
- One sub-module: alu_decoder (aluop, funct -> aluctrl), purely combinational and parametrised by ALUCTRL_W.
- FSM next-state and output logic stay in the top module.

Test Plan:
- Reset and mid-instruction: rst during MEMRD with mem_ready=0 -> next state_dbg=FETCH, all outputs 0 during rst, no regwrite.
- lw with mem_ready=1 throughout -> exactly 5 cycles (FETCH, DECODE, MEMADR, MEMRD, MEMWB); regwrite=1 with memtoreg=1 and regdst=0 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite high for 4 consecutive cycles, then FETCH; irwrite=0 throughout MEMWR.
- R-type sub (funct 100010) -> aluctrl=110 in RTEXEC, regwrite=1 with regdst=1 in RTWB; 4-cycle instruction.
- beq with zero=1 then zero=0, and bne (ENABLE_BNE=1) with zero=0 -> pcen in BRANCH = 1, 0, 1 respectively; pcsrc=01.
- ori with ENABLE_ORI=1 -> extop=0 and aluctrl=001 in IMMEXEC. With ENABLE_ORI=0 -> illegal_op pulses in DECODE and the next state is FETCH.
